// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch queue.
package fetch_pkg;

    // Queue controller states.
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } fq_state_e;

    localparam int unsigned DEPTH_DEFAULT = 4;

endpackage

// File: rtl/fetch_queue.sv
// Fetch queue between the PC register / instruction memory and decode.
// Requests are allocated in order, responses fill the oldest unfilled
// entry, and decode reads from the head once that entry is filled.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_RUN   | normal operation: requests issue, responses fill entries
// ST_DRAIN | after a flush: in-flight responses are discarded, no requests
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int SIZE  = 32,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic [SIZE-1:0] PCF,
    output logic            StallF,
    output logic            ReqValid,
    input  logic            ReqReady,
    output logic [SIZE-1:0] ReqAddr,
    input  logic            RspValid,
    input  logic [SIZE-1:0] RspData,
    input  logic            StallD,
    input  logic            FlushD,
    output logic            ValidD,
    output logic [SIZE-1:0] InstrD,
    output logic [SIZE-1:0] PCD
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [SIZE-1:0] pc_q    [DEPTH];
    logic [SIZE-1:0] instr_q [DEPTH];
    logic [DEPTH-1:0] filled_q;
    logic [PW-1:0]   alloc_q, fill_q, rd_q;
    // count_q: allocated entries; pend_q: allocated but not yet filled
    logic [CW-1:0]   count_q, pend_q, drop_q;
    fq_state_e       state_q;

    logic            fire, fill_en, deq;
    logic [CW-1:0]   count_d, pend_d, inflight, drop_d;

    // Request, delivery and handshake decode from cycle-start state.
    always_comb begin
        ReqValid = RESET_N && (state_q == ST_RUN) && !FlushD && (count_q < CW'(DEPTH));
        fire     = ReqValid && ReqReady;
        StallF   = !fire;
        ReqAddr  = PCF;
        ValidD   = RESET_N && filled_q[rd_q] && (count_q != '0) && !FlushD;
        InstrD   = instr_q[rd_q];
        PCD      = pc_q[rd_q];
        deq      = ValidD && !StallD;
        // A response with nothing outstanding is a protocol violation and is ignored.
        fill_en  = RspValid && (state_q == ST_RUN) && (pend_q != '0);
        count_d  = count_q + CW'(fire) - CW'(deq);
        pend_d   = pend_q + CW'(fire) - CW'(fill_en);
        // Responses still owed by memory; one arriving with the flush is dropped now.
        inflight = (state_q == ST_RUN) ? pend_q : drop_q;
        drop_d   = inflight - CW'(RspValid && (inflight != '0));
    end

    // Queue storage, pointers and RUN/DRAIN control.
    always_ff @(posedge CLK) begin
        if (!RESET_N || FlushD) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
            end
            filled_q <= '0;
            alloc_q  <= '0;
            fill_q   <= '0;
            rd_q     <= '0;
            count_q  <= '0;
            pend_q   <= '0;
            if (!RESET_N) begin
                drop_q  <= '0;
                state_q <= ST_RUN;
            end else begin
                drop_q  <= drop_d;
                state_q <= (drop_d != '0) ? ST_DRAIN : ST_RUN;
            end
        end else begin
            if (fire) begin
                pc_q[alloc_q]     <= PCF;
                filled_q[alloc_q] <= 1'b0;
                alloc_q           <= alloc_q + PW'(1);
            end
            if (fill_en) begin
                instr_q[fill_q]  <= RspData;
                filled_q[fill_q] <= 1'b1;
                fill_q           <= fill_q + PW'(1);
            end
            if (deq) begin
                rd_q <= rd_q + PW'(1);
            end
            count_q <= count_d;
            pend_q  <= pend_d;
            if ((state_q == ST_DRAIN) && RspValid && (drop_q != '0)) begin
                drop_q <= drop_q - CW'(1);
                if (drop_q == CW'(1)) begin
                    state_q <= ST_RUN;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios followed by a randomized run,
// checked cycle by cycle against a queue-based reference model.
module tb_fetch_queue;

    localparam int SIZE  = 32;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [SIZE-1:0] pcf;
    logic            stall_f, req_valid, req_ready;
    logic [SIZE-1:0] req_addr;
    logic            rsp_valid;
    logic [SIZE-1:0] rsp_data;
    logic            stall_d, flush_d, valid_d;
    logic [SIZE-1:0] instr_d, pc_d;

    fetch_queue #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
        .CLK(clk), .RESET_N(rst_n), .PCF(pcf), .StallF(stall_f),
        .ReqValid(req_valid), .ReqReady(req_ready), .ReqAddr(req_addr),
        .RspValid(rsp_valid), .RspData(rsp_data), .StallD(stall_d),
        .FlushD(flush_d), .ValidD(valid_d), .InstrD(instr_d), .PCD(pc_d)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic [31:0] instr; bit filled; } ent_t;
    typedef struct { logic [31:0] pc; int t; } mreq_t;

    ent_t  mq[$];     // model queue contents, oldest first
    mreq_t memq[$];   // requests outstanding at the memory
    bit    m_drain;
    int    m_drop;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [31:0] pc;
    bit rsp_ok, rnd_rsp;
    int mem_lat;
    bit last_fire, last_deq, last_vd;
    logic [31:0] last_pcd;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step(input bit ready, input bit stalld, input bit flush);
        bit rsp, exp_rv, exp_vd, m_fire, m_deq;
        logic [31:0] rdata, pc_now;
        int lat, idx;
        @(negedge clk);
        rsp = 0;
        rdata = '0;
        if (rsp_ok && memq.size() > 0 && memq[0].t <= cyc &&
            (!rnd_rsp || $urandom_range(3) != 0)) begin
            rsp = 1;
            rdata = instr_of(memq[0].pc);
        end
        pc_now    = pc;
        pcf       = pc_now;
        req_ready = ready;
        stall_d   = stalld;
        flush_d   = flush;
        rsp_valid = rsp;
        rsp_data  = rdata;
        #1;
        exp_rv = rst_n && !m_drain && !flush && (mq.size() < DEPTH);
        exp_vd = rst_n && (mq.size() > 0) && mq[0].filled && !flush;
        chk("req_valid", {31'b0, req_valid}, {31'b0, exp_rv});
        chk("stall_f",   {31'b0, stall_f},   {31'b0, !(exp_rv && ready)});
        chk("req_addr",  req_addr, pc_now);
        chk("valid_d",   {31'b0, valid_d},   {31'b0, exp_vd});
        if (exp_vd) begin
            chk("pc_d",    pc_d,    mq[0].pc);
            chk("instr_d", instr_d, mq[0].instr);
        end
        last_fire = req_valid && ready && rst_n;
        last_vd   = valid_d;
        last_deq  = valid_d && !stalld;
        last_pcd  = pc_d;

        // memory side reacts to what the DUT actually issued
        if (rsp) void'(memq.pop_front());
        if (last_fire) begin
            lat = rnd_rsp ? $urandom_range(1, 3) : mem_lat;
            memq.push_back('{pc: pc_now, t: cyc + lat});
            pc = pc + 4;
        end

        // reference model update
        m_fire = exp_rv && ready;
        m_deq  = exp_vd && !stalld;
        if (!rst_n) begin
            mq.delete();
            m_drain = 0;
            m_drop  = 0;
        end else if (flush) begin
            int infl;
            infl = 0;
            if (m_drain) infl = m_drop;
            else foreach (mq[i]) if (!mq[i].filled) infl++;
            if (rsp && infl > 0) infl--;
            mq.delete();
            m_drop  = infl;
            m_drain = (infl > 0);
        end else begin
            if (rsp) begin
                if (m_drain) begin
                    m_drop--;
                    if (m_drop == 0) m_drain = 0;
                end else begin
                    idx = -1;
                    foreach (mq[i]) if (idx < 0 && !mq[i].filled) idx = i;
                    if (idx >= 0) begin
                        mq[idx].filled = 1;
                        mq[idx].instr  = rdata;
                    end
                end
            end
            if (m_deq) void'(mq.pop_front());
            if (m_fire) mq.push_back('{pc: pc_now, instr: 32'h0, filled: 1'b0});
        end
        cyc++;
    endtask

    initial begin
        int first_fire, first_vd, fires, deqs;
        bit seen100;
        pc = 32'h0; rsp_ok = 1; rnd_rsp = 0; mem_lat = 1;
        m_drain = 0; m_drop = 0;
        pcf = '0; req_ready = 0; stall_d = 0; flush_d = 0; rsp_valid = 0; rsp_data = '0;

        // reset held two cycles with flush asserted
        rst_n = 0;
        step(1, 0, 1);
        step(1, 0, 1);
        rst_n = 1;

        // streaming with a one-cycle memory
        first_fire = -1; first_vd = -1;
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 0);
            if (i == 0) begin
                chk("rst_release_req_valid", {31'b0, req_valid}, 32'd1);
                chk("rst_pc_d", pc_d, 32'h0);
                chk("rst_instr_d", instr_d, 32'h0);
            end
            if (last_fire && first_fire < 0) first_fire = i;
            if (last_vd && first_vd < 0) first_vd = i;
        end
        chk("stream_latency", first_vd - first_fire, 32'd2);

        // drain, then fill the queue with decode stalled
        for (int i = 0; i < 4; i++) step(0, 0, 0);
        fires = 0;
        for (int i = 0; i < 7; i++) begin
            step(1, 1, 0);
            fires += int'(last_fire);
        end
        chk("full_fires", fires, 32'd4);
        step(1, 0, 0);
        chk("full_one_deq", {31'b0, last_deq}, 32'd1);
        chk("full_no_fire_same", {31'b0, last_fire}, 32'd0);
        step(1, 1, 0);
        chk("full_refire", {31'b0, last_fire}, 32'd1);
        for (int i = 0; i < 7; i++) step(0, 0, 0);

        // flush with two unfilled entries; new stream at 0x100
        rsp_ok = 0;
        step(1, 1, 0);
        step(1, 1, 0);
        step(0, 1, 0);
        pc = 32'h100;
        step(1, 0, 1);
        rsp_ok = 1;
        step(1, 0, 0);
        chk("drain_hold_1", {31'b0, last_fire}, 32'd0);
        step(1, 0, 0);
        chk("drain_hold_2", {31'b0, last_fire}, 32'd0);
        seen100 = 0;
        for (int i = 0; i < 6; i++) begin
            step(1, 0, 0);
            if (last_vd && last_pcd == 32'h100) seen100 = 1;
        end
        chk("flush_refetch_0x100", {31'b0, seen100}, 32'd1);

        // backpressure from memory
        fires = 0;
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0);
            fires += int'(last_fire);
        end
        chk("backpressure_fires", fires, 32'd0);
        for (int i = 0; i < 6; i++) step(0, 0, 0);

        // flush coinciding with the only outstanding response
        rsp_ok = 0;
        step(1, 0, 0);
        step(0, 0, 0);
        rsp_ok = 1;
        step(0, 0, 1);
        step(1, 0, 0);
        chk("flush_rsp_run", {31'b0, req_valid}, 32'd1);
        chk("flush_rsp_no_valid", {31'b0, valid_d}, 32'd0);

        // randomized traffic
        rnd_rsp = 1;
        for (int i = 0; i < 3000; i++) begin
            bit fl;
            fl = ($urandom_range(63) == 0);
            if (fl && $urandom_range(1) == 1) pc = {$urandom_range(32'hFFFF), 2'b00};
            step($urandom_range(3) != 0, $urandom_range(3) == 0, fl);
        end
        for (int i = 0; i < 20; i++) step(0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
